// File: rtl/imem_loadable.sv
// imem_loadable: loadable instruction memory for the MIPS datapath.
// Registered one-cycle fetch port plus a byte-serial, big-endian program-load
// port. A two-state FSM (RUN / LOAD) arbitrates between fetch and load.
// Optional feature macro: IMEM_ALIGN_CHECK_EN (flags misaligned fetches).
module imem_loadable #(
    parameter int DEPTH_LOG2 = 10,
    parameter int ADDR_W     = 32
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  fetch_req_i,
    input  logic [ADDR_W-1:0]     fetch_addr_i,
    output logic [31:0]           instr_o,
    output logic                  instr_valid_o,
    input  logic                  load_start_i,
    input  logic                  load_byte_valid_i,
    input  logic [7:0]            load_byte_i,
    input  logic                  load_last_i,
    output logic                  load_ready_o,
    output logic                  busy_o,
    output logic [DEPTH_LOG2:0]   loaded_words_o,
    output logic                  overflow_o,
    output logic                  align_fault_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic {S_RUN, S_LOAD} state_t;

    state_t                state_q, state_d;
    logic [1:0]            lane_q, lane_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2:0]   words_q, words_d;
    logic                  ovf_q, ovf_d;
    logic [31:0]           asm_q, asm_d;
    logic [31:0]           instr_q;
    logic                  ivld_q;
    logic                  afault_q;

    // Zero (NOP) at time zero; never cleared by reset.
    logic [31:0]           mem_q [DEPTH] = '{default: 32'h0};

    logic                  mem_we;
    logic [31:0]           wdata;
    logic [31:0]           byte_word;
    logic                  accept;
    logic                  word_done;
    logic                  full;
    logic                  fetch_en;
    logic                  misaligned;
    logic [DEPTH_LOG2-1:0] rd_idx;
    logic                  unused_addr;

    // Upper address bits alias away; the low two bits only matter with the check on.
    assign unused_addr = ^fetch_addr_i;
    assign rd_idx      = fetch_addr_i[DEPTH_LOG2+1:2];

`ifdef IMEM_ALIGN_CHECK_EN
    assign misaligned = |fetch_addr_i[1:0];
`else
    assign misaligned = 1'b0;
`endif

    // Current byte placed in its big-endian lane; lower lanes read as zero.
    assign byte_word = {load_byte_i, 24'h0} >> {lane_q, 3'b000};
    assign wdata     = asm_q | byte_word;
    assign accept    = (state_q == S_LOAD) && load_byte_valid_i;
    assign word_done = accept && ((lane_q == 2'd3) || load_last_i);
    // All DEPTH words written: loaded_words has reached DEPTH.
    assign full      = words_q[DEPTH_LOG2];
    // load_start wins over a same-cycle fetch; the fetch is dropped.
    assign fetch_en  = (state_q == S_RUN) && !load_start_i && fetch_req_i;

    // Next-state logic for the FSM and the load-side registers.
    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        wr_ptr_d = wr_ptr_q;
        words_d = words_q;
        ovf_d   = ovf_q;
        asm_d   = asm_q;
        mem_we  = 1'b0;
        case (state_q)
            S_RUN: begin
                if (load_start_i) begin
                    state_d  = S_LOAD;
                    lane_d   = 2'd0;
                    wr_ptr_d = '0;
                    words_d  = '0;
                    ovf_d    = 1'b0;
                    asm_d    = '0;
                end
            end
            S_LOAD: begin
                if (accept) begin
                    if (word_done) begin
                        // Completed (or zero-padded final) word.
                        if (full) begin
                            ovf_d = 1'b1;
                        end else begin
                            mem_we   = 1'b1;
                            wr_ptr_d = wr_ptr_q + 1'b1;
                            words_d  = words_q + 1'b1;
                        end
                        lane_d = 2'd0;
                        asm_d  = '0;
                    end else begin
                        lane_d = lane_q + 2'd1;
                        asm_d  = wdata;
                    end
                    if (load_last_i) begin
                        state_d = S_RUN;
                    end
                end
            end
            default: state_d = S_RUN;
        endcase
    end

    // State and load-side registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= S_RUN;
            lane_q   <= 2'd0;
            wr_ptr_q <= '0;
            words_q  <= '0;
            ovf_q    <= 1'b0;
            asm_q    <= '0;
        end else begin
            state_q  <= state_d;
            lane_q   <= lane_d;
            wr_ptr_q <= wr_ptr_d;
            words_q  <= words_d;
            ovf_q    <= ovf_d;
            asm_q    <= asm_d;
        end
    end

    // Memory write port; a word completing under reset is discarded.
    always_ff @(posedge clk_i) begin
        if (mem_we && !reset_i) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    // Registered fetch port: one response cycle per accepted request.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            instr_q  <= '0;
            ivld_q   <= 1'b0;
            afault_q <= 1'b0;
        end else begin
            ivld_q   <= fetch_en;
            afault_q <= fetch_en && misaligned;
            if (fetch_en) begin
                instr_q <= misaligned ? 32'h0 : mem_q[rd_idx];
            end
        end
    end

    assign instr_o        = instr_q;
    assign instr_valid_o  = ivld_q;
    assign align_fault_o  = afault_q;
    assign load_ready_o   = (state_q == S_LOAD);
    assign busy_o         = (state_q == S_LOAD);
    assign loaded_words_o = words_q;
    assign overflow_o     = ovf_q;

endmodule

// File: tb/tb_imem_loadable.sv
// Scoreboard bench for imem_loadable: a default-depth instance and a
// 4-word instance for overflow / reset-abort cases.
module tb_imem_loadable;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

`ifdef IMEM_ALIGN_CHECK_EN
    localparam bit ALIGN_ON = 1'b1;
`else
    localparam bit ALIGN_ON = 1'b0;
`endif

    // Big instance (DEPTH_LOG2 = 10) signals
    logic        b_rst, b_freq, b_ls, b_lbv, b_ll;
    logic [31:0] b_addr;
    logic [7:0]  b_lb;
    logic [31:0] b_instr;
    logic        b_ivld, b_lrdy, b_busy, b_ovf, b_af;
    logic [10:0] b_words;

    // Small instance (DEPTH_LOG2 = 2) signals
    logic        s_rst, s_freq, s_ls, s_lbv, s_ll;
    logic [31:0] s_addr;
    logic [7:0]  s_lb;
    logic [31:0] s_instr;
    logic        s_ivld, s_lrdy, s_busy, s_ovf, s_af;
    logic [2:0]  s_words;

    imem_loadable #(.DEPTH_LOG2(10), .ADDR_W(32)) u_dut (
        .clk_i(clk), .reset_i(b_rst), .fetch_req_i(b_freq), .fetch_addr_i(b_addr),
        .instr_o(b_instr), .instr_valid_o(b_ivld), .load_start_i(b_ls),
        .load_byte_valid_i(b_lbv), .load_byte_i(b_lb), .load_last_i(b_ll),
        .load_ready_o(b_lrdy), .busy_o(b_busy), .loaded_words_o(b_words),
        .overflow_o(b_ovf), .align_fault_o(b_af)
    );

    imem_loadable #(.DEPTH_LOG2(2), .ADDR_W(32)) u_small (
        .clk_i(clk), .reset_i(s_rst), .fetch_req_i(s_freq), .fetch_addr_i(s_addr),
        .instr_o(s_instr), .instr_valid_o(s_ivld), .load_start_i(s_ls),
        .load_byte_valid_i(s_lbv), .load_byte_i(s_lb), .load_last_i(s_ll),
        .load_ready_o(s_lrdy), .busy_o(s_busy), .loaded_words_o(s_words),
        .overflow_o(s_ovf), .align_fault_o(s_af)
    );

    // Expected responses: {align_fault, instr}
    logic [32:0] q_b[$];
    logic [32:0] q_s[$];
    logic [7:0]  img[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Scoreboard monitors: pop and compare on every valid response.
    always @(negedge clk) begin
        if (b_ivld === 1'b1) begin
            if (q_b.size() == 0) chk("b_unexp_vld", 32'd1, 32'd0);
            else begin
                logic [32:0] e;
                e = q_b.pop_front();
                chk("b_instr", b_instr, e[31:0]);
                chk("b_align", {31'd0, b_af}, {31'd0, e[32]});
            end
        end
    end

    always @(negedge clk) begin
        if (s_ivld === 1'b1) begin
            if (q_s.size() == 0) chk("s_unexp_vld", 32'd1, 32'd0);
            else begin
                logic [32:0] e;
                e = q_s.pop_front();
                chk("s_instr", s_instr, e[31:0]);
                chk("s_align", {31'd0, s_af}, {31'd0, e[32]});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input bit sm, input logic ls, input logic v, input logic [7:0] b,
                       input logic l);
        if (sm) begin s_ls = ls; s_lbv = v; s_lb = b; s_ll = l; end
        else    begin b_ls = ls; b_lbv = v; b_lb = b; b_ll = l; end
    endtask

    // One fetch request; the expected response goes on the scoreboard.
    task automatic fetch(input bit sm, input logic [31:0] a, input logic [31:0] exp,
                         input logic af);
        if (sm) begin s_freq = 1'b1; s_addr = a; q_s.push_back({af, exp}); end
        else    begin b_freq = 1'b1; b_addr = a; q_b.push_back({af, exp}); end
        tick();
        b_freq = 1'b0;
        s_freq = 1'b0;
    endtask

    task automatic drain(input string tag);
        tick();
        tick();
        chk({tag, "_qb"}, q_b.size(), 32'd0);
        chk({tag, "_qs"}, q_s.size(), 32'd0);
        q_b.delete();
        q_s.delete();
    endtask

    // Stream img; last flag on final byte only if with_last.
    task automatic load_img(input bit sm, input bit with_last);
        drv(sm, 1'b1, 1'b0, 8'h0, 1'b0);
        tick();
        drv(sm, 1'b0, 1'b0, 8'h0, 1'b0);
        chk("busy_rise", {31'd0, sm ? s_busy : b_busy}, 32'd1);
        chk("ready_load", {31'd0, sm ? s_lrdy : b_lrdy}, 32'd1);
        for (int i = 0; i < img.size(); i++) begin
            drv(sm, 1'b0, 1'b1, img[i], with_last && (i == img.size() - 1));
            tick();
        end
        drv(sm, 1'b0, 1'b0, 8'h0, 1'b0);
    endtask

    initial begin
        b_rst = 1'b1; s_rst = 1'b1;
        b_freq = 1'b0; s_freq = 1'b0; b_addr = '0; s_addr = '0;
        drv(1'b0, 1'b0, 1'b0, 8'h0, 1'b0);
        drv(1'b1, 1'b0, 1'b0, 8'h0, 1'b0);
        tick();
        tick();
        b_rst = 1'b0; s_rst = 1'b0;

        // Reset state
        chk("rst_instr", b_instr, 32'h0);
        chk("rst_vld", {31'd0, b_ivld}, 32'd0);
        chk("rst_ready", {31'd0, b_lrdy}, 32'd0);
        chk("rst_busy", {31'd0, b_busy}, 32'd0);
        chk("rst_words", {21'd0, b_words}, 32'd0);
        chk("rst_ovf", {31'd0, b_ovf}, 32'd0);
        chk("rst_af", {31'd0, b_af}, 32'd0);

        // Fresh memory reads NOP, back-to-back
        fetch(1'b0, 32'h0, 32'h0, 1'b0);
        fetch(1'b0, 32'hFFC, 32'h0, 1'b0);
        drain("nop");

        // Two-word program
        img = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h04};
        load_img(1'b0, 1'b1);
        chk("ld1_busy_fall", {31'd0, b_busy}, 32'd0);
        chk("ld1_words", {21'd0, b_words}, 32'd2);
        chk("ld1_ovf", {31'd0, b_ovf}, 32'd0);
        fetch(1'b0, 32'h0, 32'h20080005, 1'b0);
        fetch(1'b0, 32'h4, 32'h8C090004, 1'b0);
        fetch(1'b0, 32'h1004, 32'h8C090004, 1'b0);
        drain("ld1");

        // Partial final word zero-padded
        img = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11};
        load_img(1'b0, 1'b1);
        chk("ld2_words", {21'd0, b_words}, 32'd2);
        fetch(1'b0, 32'h0, 32'hAABBCCDD, 1'b0);
        fetch(1'b0, 32'h4, 32'h11000000, 1'b0);
        drain("ld2");

        // Misaligned fetch of word 1
        fetch(1'b0, 32'h6, ALIGN_ON ? 32'h0 : 32'h11000000, ALIGN_ON);
        drain("align");

        // load_start with a simultaneous fetch: fetch dropped
        b_ls = 1'b1; b_freq = 1'b1; b_addr = 32'h4;
        tick();
        b_ls = 1'b0; b_freq = 1'b0;
        chk("drop_vld", {31'd0, b_ivld}, 32'd0);
        chk("drop_busy", {31'd0, b_busy}, 32'd1);
        // load_start inside LOAD is ignored; single zero-padded byte follows
        b_ls = 1'b1;
        tick();
        b_ls = 1'b0;
        drv(1'b0, 1'b0, 1'b1, 8'h77, 1'b1);
        tick();
        drv(1'b0, 1'b0, 1'b0, 8'h0, 1'b0);
        chk("ld3_busy", {31'd0, b_busy}, 32'd0);
        chk("ld3_words", {21'd0, b_words}, 32'd1);
        fetch(1'b0, 32'h0, 32'h77000000, 1'b0);
        fetch(1'b0, 32'h4, 32'h11000000, 1'b0);
        drain("ld3");

        // Small instance: reset aborts a load after 6 bytes
        img = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        load_img(1'b1, 1'b0);
        chk("abort_busy_pre", {31'd0, s_busy}, 32'd1);
        chk("abort_words_pre", {29'd0, s_words}, 32'd1);
        s_rst = 1'b1;
        tick();
        s_rst = 1'b0;
        chk("abort_busy", {31'd0, s_busy}, 32'd0);
        chk("abort_ready", {31'd0, s_lrdy}, 32'd0);
        chk("abort_words", {29'd0, s_words}, 32'd0);
        fetch(1'b1, 32'h0, 32'h01020304, 1'b0);
        fetch(1'b1, 32'h4, 32'h0, 1'b0);
        drain("abort");

        // Small instance: 20-byte image overflows 4 words
        img.delete();
        for (int i = 0; i < 20; i++) img.push_back(8'(i));
        load_img(1'b1, 1'b1);
        chk("ovf_flag", {31'd0, s_ovf}, 32'd1);
        chk("ovf_words", {29'd0, s_words}, 32'd4);
        chk("ovf_busy", {31'd0, s_busy}, 32'd0);
        fetch(1'b1, 32'h0, 32'h00010203, 1'b0);
        fetch(1'b1, 32'h4, 32'h04050607, 1'b0);
        fetch(1'b1, 32'h8, 32'h08090A0B, 1'b0);
        fetch(1'b1, 32'hC, 32'h0C0D0E0F, 1'b0);
        fetch(1'b1, 32'h10, 32'h00010203, 1'b0);
        drain("ovf");
        chk("ovf_sticky", {31'd0, s_ovf}, 32'd1);

        // New load clears overflow
        img = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        load_img(1'b1, 1'b1);
        chk("ovf_clr", {31'd0, s_ovf}, 32'd0);
        chk("ovf_clr_words", {29'd0, s_words}, 32'd1);
        fetch(1'b1, 32'h0, 32'hDEADBEEF, 1'b0);
        fetch(1'b1, 32'h4, 32'h04050607, 1'b0);
        drain("reload");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
